score_counter: RTL and testbench



---
 rtl/score_counter.sv | 90 +++++++++
 tb/tb_score_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// score_counter: saturating bowling hit counter with two-digit 7-segment readout.
// Ports: CLOCK_50 clock; SW[0] sync active-low reset; KEY[0] active-low hit
//   button (asynchronous); score 5-bit binary total; HEX0 units / HEX1 tens,
//   active-low segments, bit 0 = a .. bit 6 = g.
// Parameter MAX_SCORE (<= 31) is the saturation value.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks HEX1 while the tens digit is 0.
module score_counter #(
    parameter int MAX_SCORE = 30
) (
    input  logic       CLOCK_50,
    input  logic [0:0] SW,
    input  logic [0:0] KEY,
    output logic [4:0] score,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam logic [4:0] SCORE_MAX = 5'(MAX_SCORE);

    // k1/k2 synchronize the button; kp holds the previous synchronized
    // level so a press is counted once, on the falling edge only.
    logic k1;
    logic k2;
    logic kp;
    logic press;

    assign press = kp & ~k2;

    always_ff @(posedge CLOCK_50) begin
        if (!SW[0]) begin
            k1    <= 1'b1;
            k2    <= 1'b1;
            kp    <= 1'b1;
            score <= 5'd0;
        end else begin
            k1 <= KEY[0];
            k2 <= k1;
            kp <= k2;
            if (press && (score < SCORE_MAX))
                score <= score + 5'd1;
        end
    end

    // Score never exceeds 31, so the tens digit is 0..3 and a
    // compare/subtract ladder replaces a general divider.
    logic [4:0] tens;
    logic [4:0] units;

    always_comb begin
        tens  = 5'd0;
        units = score;
        if (score >= 5'd30) begin
            tens  = 5'd3;
            units = score - 5'd30;
        end else if (score >= 5'd20) begin
            tens  = 5'd2;
            units = score - 5'd20;
        end else if (score >= 5'd10) begin
            tens  = 5'd1;
            units = score - 5'd10;
        end
    end

    function automatic logic [6:0] seg7(input logic [4:0] d);
        logic [6:0] s;
        unique case (d)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign HEX0 = seg7(units);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign HEX1 = (tens == 5'd0) ? 7'b1111111 : seg7(tens);
`else
    assign HEX1 = seg7(tens);
`endif

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: table vectors, corner sequences and random stimulus
// checked against a press-history model of the bowling counter.
module tb_score_counter;

    localparam int MAX = 30;

    logic       CLOCK_50;
    logic [0:0] SW;
    logic [0:0] KEY;
    logic [4:0] score;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    int checks;
    int failures;

    score_counter #(.MAX_SCORE(MAX)) dut (
        .CLOCK_50(CLOCK_50),
        .SW(SW),
        .KEY(KEY),
        .score(score),
        .HEX0(HEX0),
        .HEX1(HEX1)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Model: every KEY level sampled since reset release. A falling edge
    // of that sampled sequence (starting from "released") counts two
    // edges later; the total is clipped at MAX.
    bit samp_q[$];
    int exp_score;

    function automatic int model_score();
        int c;
        bit prev;
        c = 0;
        for (int i = 0; i <= int'(samp_q.size()) - 3; i++) begin
            prev = (i == 0) ? 1'b1 : samp_q[i-1];
            if (prev && !samp_q[i])
                c++;
        end
        return (c > MAX) ? MAX : c;
    endfunction

    function automatic logic [6:0] exp_hex(input int s, input bit hi);
        int d;
        d = hi ? s / 10 : s % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (hi && d == 0)
            return 7'b1111111;
`endif
        return seg_tab[d];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_disp(input string name, input int s);
        chk({name, ".score"}, int'(score), s);
        chk({name, ".hex0"}, int'(HEX0), int'(exp_hex(s, 1'b0)));
        chk({name, ".hex1"}, int'(HEX1), int'(exp_hex(s, 1'b1)));
    endtask

    task automatic step(input bit sw, input bit key);
        SW[0]  = sw;
        KEY[0] = key;
        @(posedge CLOCK_50);
        if (!sw)
            samp_q.delete();
        else
            samp_q.push_back(key);
        exp_score = model_score();
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic presses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
    endtask

    typedef struct {
        bit sw;
        bit key;
        int score;
    } vec_t;

    vec_t vt [15];

    initial begin
        checks    = 0;
        failures  = 0;
        exp_score = 0;
        SW[0]     = 1'b0;
        KEY[0]    = 1'b1;

        vt[0]  = '{1'b0, 1'b1, 0};
        vt[1]  = '{1'b0, 1'b1, 0};
        vt[2]  = '{1'b1, 1'b1, 0};
        vt[3]  = '{1'b1, 1'b0, 0};
        vt[4]  = '{1'b1, 1'b1, 0};
        vt[5]  = '{1'b1, 1'b0, 1};
        vt[6]  = '{1'b1, 1'b1, 1};
        vt[7]  = '{1'b1, 1'b0, 2};
        vt[8]  = '{1'b1, 1'b1, 2};
        vt[9]  = '{1'b1, 1'b0, 3};
        vt[10] = '{1'b1, 1'b1, 3};
        vt[11] = '{1'b1, 1'b0, 4};
        vt[12] = '{1'b1, 1'b1, 4};
        vt[13] = '{1'b1, 1'b1, 5};
        vt[14] = '{1'b1, 1'b1, 5};

        // Reset state, then five one-cycle presses with 2-cycle latency.
        for (int i = 0; i < 15; i++) begin
            step(vt[i].sw, vt[i].key);
            chk_disp($sformatf("vec%0d", i), vt[i].score);
        end
        chk("vec.hex0_5", int'(HEX0), int'(7'b0010010));

        // Reset then 15 presses.
        do_reset();
        chk_disp("rst", 0);
        presses(15);
        chk_disp("p15", 15);
        chk("p15.hex1", int'(HEX1), int'(7'b1111001));

        // Saturation: 35 presses from 0, never exceeding MAX.
        do_reset();
        for (int i = 0; i < 35; i++) begin
            step(1'b1, 1'b0);
            if (score > 5'(MAX)) chk("sat.bound", int'(score), MAX);
            step(1'b1, 1'b1);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk_disp("sat", 30);
        chk("sat.hex1", int'(HEX1), int'(7'b0110000));
        chk("sat.hex0", int'(HEX0), int'(7'b1000000));

        // Held button from 7: exactly one increment, release adds nothing.
        do_reset();
        presses(7);
        chk("hold.pre", int'(score), 7);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0);
        chk("hold.low", int'(score), 8);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1);
        chk_disp("hold.rel", 8);

        // Reset lands on the edge the press event would fire.
        do_reset();
        presses(12);
        chk("rp.pre", int'(score), 12);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("rp.edge", int'(score), 0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1);
        chk_disp("rp.after", 0);

        // Key held low across reset release counts once after release.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("hr.lat", int'(score), 0);
        step(1'b1, 1'b0);
        chk("hr.one", int'(score), 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk_disp("hr.end", 1);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)));
            chk_disp("rnd", exp_score);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
